// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between execute and a word-wide data memory.
// Converts RV32I byte/half/word accesses into word reads and writes, using a
// read-modify-write sequence for sub-word stores and sign/zero-extending loads.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_ready is high only while idle, and the response is a single-cycle
// resp_valid pulse carrying resp_rdata/resp_err (which then hold their values
// until the next response).
module lsu_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_r_wr,
    output logic [ADDR_W-1:0] mem_daddr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          addr_q, addr_d;      // byte offset within the word
    logic [15:0]         wdata_q, wdata_d;    // only the low half feeds a merge
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic [31:0]         din_q, din_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req_legal;
    logic                req_misaligned;
    logic [31:0]         lane_shifted;
    logic [31:0]         load_ext;
    logic [31:0]         merged;

    // Byte-address bits above the word address never reach d_mem.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Classify the incoming request: legal funct3 for its direction, and alignment.
    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        case (req_funct3)
            3'b000: req_legal = 1'b1;
            3'b001: begin
                req_legal      = 1'b1;
                req_misaligned = req_addr[0];
            end
            3'b010: begin
                req_legal      = 1'b1;
                req_misaligned = |req_addr[1:0];
            end
            3'b100: req_legal = req_load;
            3'b101: begin
                req_legal      = req_load;
                req_misaligned = req_addr[0];
            end
            default: req_legal = 1'b0;
        endcase
    end

    // Load lane extraction: shift the addressed lane down, then extend by funct3.
    always_comb begin
        lane_shifted = mem_dout >> {addr_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
            3'b001:  load_ext = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
            3'b100:  load_ext = {24'd0, lane_shifted[7:0]};
            3'b101:  load_ext = {16'd0, lane_shifted[15:0]};
            default: load_ext = mem_dout;
        endcase
    end

    // Sub-word store merge: overlay the store byte/half onto the word just read.
    always_comb begin
        merged = mem_dout;
        if (funct3_q[1:0] == 2'b01) begin
            if (addr_q[1]) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end else begin
            case (addr_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        daddr_d  = daddr_q;
        din_d    = din_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr[1:0];
                    wdata_d  = req_wdata[15:0];
                    if (!req_legal || req_misaligned) begin
                        // Rejected without touching memory.
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        daddr_d = req_addr[ADDR_W+1:2];
                        if (req_load) begin
                            state_d = S_LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            din_d   = req_wdata;
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_ext;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                din_d   = merged;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async reset forces idle and read mode at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct3_q <= 3'd0;
            addr_q   <= 2'd0;
            wdata_q  <= 16'd0;
            daddr_q  <= '0;
            din_q    <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            daddr_q  <= daddr_d;
            din_q    <= din_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_r_wr   = (state_q != S_WRITE);
    assign mem_daddr  = daddr_q;
    assign mem_din    = din_q;
    assign dbg_state  = state_q;

endmodule
